mt_maint_wrap: RTL and testbench
================================

Name: mt_maint_wrap

Overview:
- Maintenance wraparound data generator for the MT (TM03/TU45) tape path.
- Sits directly downstream of the MT Maintenance Register. Consumes the 16-bit mtMR image and its write strobe.
- When maintenance mode is set, emits a programmable stream of simulated tape frames (constant, incrementing, or rotating pattern seeded from the maintenance data field) to the read data path over a valid/ready handshake.
- Produces the emulated BPI clock pulse.

Parameters:
- FRAMES, 16, number of frames per maintenance run (1..255).
- BPIDIV, 8, clk cycles per emulated BPI clock period, i.e. frame spacing (2..65535).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mtMR  input  16  maintenance register image: MDF[15:7], BPICLK[6], MC[5], MOP[4:1], MM[0]
- mtmrWRITE  input  1  one-cycle strobe; mtMR holds the new value on the following cycle
- mtMDAT  output  10  frame data: [8:0] pattern, [9] parity (see Optional Feature)
- mtMVALID  output  1  frame valid
- mtMREADY  input  1  downstream accepts frame
- mtMBUSY  output  1  run in progress
- mtMDONE  output  1  sticky; run completed normally
- mtMILL  output  1  sticky; illegal MOP written with MM=1
- mtBPICLK  output  1  one-cycle pulse at each divider terminal count
- mtMFCNT  output  8  frames accepted in the current or last run

Behaviour:
- Reset values (synchronous): all outputs 0, state IDLE, divider 0, pattern 0.
- Write strobe handling:
  - mtmrWRITE is registered to writeD.
  - All decisions use mtMR during the cycle writeD=1.
- MOP decode:
  - 0: no-op.
  - 1: WRAP_CONST, pattern unchanged.
  - 2: WRAP_INC, pattern+1 modulo 512 (0x1FF -> 0x000).
  - 3: WRAP_ROT, 9-bit rotate left, bit 8 -> bit 0.
  - 4..15: illegal.
- Start: writeD=1, MM=1, MOP in 1..3. On that edge:
  - state <= WAIT, pattern <= MDF, divider <= BPIDIV-1, mtMFCNT <= 0.
  - mtMDONE, mtMILL cleared; mtMBUSY <= 1.
- States:
  - IDLE: valid=0, busy=0.
  - WAIT: divider decrements each cycle. At divider==0: mtBPICLK pulses that cycle and state <= EMIT.
  - EMIT: mtMVALID=1. mtMDAT stable until accepted. On mtMVALID&mtMREADY:
    - mtMFCNT+1 and pattern advances per MOP.
    - If new count == FRAMES: state <= DONE. Otherwise state <= WAIT with divider <= BPIDIV-1.
  - DONE (one cycle): mtMDONE <= 1, mtMBUSY <= 0, state <= IDLE.
- Latency:
  - Write at cycle T; writeD at T+1.
  - WAIT occupies T+2..T+1+BPIDIV.
  - First mtMVALID at T+2+BPIDIV.
  - With mtMREADY held high, frame spacing is BPIDIV+1 cycles.
- Handshake:
  - mtMVALID never drops without acceptance, except on abort or reset.
  - mtMDAT must not change while valid and not ready.
- Divider behaviour: does not run during EMIT. No mtBPICLK pulses outside WAIT.
- Write while busy (writeD=1 in any non-IDLE state):
  - MM=0 or MOP=0: abort. State <= IDLE, valid and busy cleared next cycle, mtMDONE not set, mtMFCNT held.
  - Legal MOP with MM=1: restart as Start (pattern reseeded, count cleared).
  - Illegal MOP with MM=1: abort and set mtMILL.
- Write in IDLE with MM=1 and illegal MOP: sets mtMILL, no run.
- Write with MM=0: never sets mtMILL.
- Frames accepted on the same edge as an abort write are lost. The abort has priority and the count is not incremented.
- The mtMR BPICLK and MC bits are ignored by this block.
- Reset mid-run: all outputs 0 on the next edge, no partial completion flag.

Optional Feature:
- Macro: MTMAINT_PARITY_EN.
- Defined: mtMDAT[9] is odd parity over mtMDAT[8:0], so ^mtMDAT == 1. Generated combinationally from the pattern register, valid in the same cycle as the data.
- Undefined: mtMDAT[9] is tied 0. No parity logic is instantiated.

Test Plan:
- MDF=0x0A5, MOP=1, MM=1, FRAMES=4, BPIDIV=8, ready high -> 4 frames of 0x0A5, first valid at T+10, spacing 9 cycles, 4 mtBPICLK pulses, mtMDONE=1, mtMFCNT=4.
- MDF=0x1FE, MOP=2, FRAMES=4 -> frames 0x1FE, 0x1FF, 0x000, 0x001. Then MOP=3, MDF=0x101 -> 0x101, 0x003, 0x006, 0x00C.
- Backpressure: mtMREADY low for 20 cycles during the first EMIT -> mtMDAT held stable, no mtBPICLK pulses, frame count unaffected; the run completes after release.
- Abort: after 2 frames, write MM=0 -> valid low next cycle, mtMBUSY=0, mtMDONE=0, mtMFCNT=2. Write MM=1, MOP=9 -> mtMILL=1, no run.
- Reset asserted while valid and not ready -> all outputs 0 next cycle. A subsequent legal write starts a clean run with mtMFCNT=0.
- With MTMAINT_PARITY_EN, MDF=0x000 -> mtMDAT=0x200. Without the macro -> 0x000.

Source files
------------

// File: rtl/mt_maint_wrap.sv
`default_nettype none
// ============================================================================
// Module   : mt_maint_wrap
// Purpose  : MT maintenance wraparound frame generator with emulated BPI clock.
//            Define MTMAINT_PARITY_EN to drive odd parity on mtMDAT[9].
// Revision : 1.0  initial release
// ============================================================================
module mt_maint_wrap #(
  parameter int FRAMES = 16,
  parameter int BPIDIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mtMR,
  input  logic        mtmrWRITE,
  output logic [9:0]  mtMDAT,
  output logic        mtMVALID,
  input  logic        mtMREADY,
  output logic        mtMBUSY,
  output logic        mtMDONE,
  output logic        mtMILL,
  output logic        mtBPICLK,
  output logic [7:0]  mtMFCNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] c_divReload = 16'(BPIDIV - 1);
  localparam logic [7:0]  c_frames    = 8'(FRAMES);

  logic        r_writeD;
  state_t      r_state,   w_nextState;
  logic [15:0] r_divider, w_nextDivider;
  logic [8:0]  r_pattern, w_nextPattern;
  logic [1:0]  r_mop,     w_nextMop;
  logic [7:0]  r_fcnt,    w_nextFcnt;
  logic        r_done,    w_nextDone;
  logic        r_ill,     w_nextIll;

  logic [8:0]  w_mdf;
  logic [3:0]  w_mop;
  logic        w_mm;
  logic        w_legal;
  logic        w_illegal;
  logic        w_busy;
  logic        w_accept;
  logic [8:0]  w_advPattern;
  logic [7:0]  w_fcntInc;
  logic        w_parity;
  logic        w_unusedMrBits;

  assign w_mdf          = mtMR[15:7];
  assign w_mop          = mtMR[4:1];
  assign w_mm           = mtMR[0];
  assign w_unusedMrBits = |mtMR[6:5];
  assign w_legal        = (w_mop >= 4'd1) && (w_mop <= 4'd3);
  assign w_illegal      = (w_mop >= 4'd4);
  assign w_busy         = (r_state != IDLE);
  assign w_accept       = (r_state == EMIT) && mtMREADY;
  assign w_fcntInc      = r_fcnt + 8'd1;

  always_comb begin
    w_advPattern = r_pattern;
    case (r_mop)
      2'd2:    w_advPattern = r_pattern + 9'd1;
      2'd3:    w_advPattern = {r_pattern[7:0], r_pattern[8]};
      default: w_advPattern = r_pattern;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_writeD  <= 1'b0;
      r_state   <= IDLE;
      r_divider <= 16'd0;
      r_pattern <= 9'd0;
      r_mop     <= 2'd0;
      r_fcnt    <= 8'd0;
      r_done    <= 1'b0;
      r_ill     <= 1'b0;
    end else begin
      r_writeD  <= mtmrWRITE;
      r_state   <= w_nextState;
      r_divider <= w_nextDivider;
      r_pattern <= w_nextPattern;
      r_mop     <= w_nextMop;
      r_fcnt    <= w_nextFcnt;
      r_done    <= w_nextDone;
      r_ill     <= w_nextIll;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextDivider = r_divider;
    w_nextPattern = r_pattern;
    w_nextMop     = r_mop;
    w_nextFcnt    = r_fcnt;
    w_nextDone    = r_done;
    w_nextIll     = r_ill;

    case (r_state)
      WAIT: begin
        if (r_divider == 16'd0) w_nextState = EMIT;
        else                    w_nextDivider = r_divider - 16'd1;
      end
      EMIT: begin
        if (w_accept) begin
          w_nextFcnt    = w_fcntInc;
          w_nextPattern = w_advPattern;
          if (w_fcntInc == c_frames) begin
            w_nextState = DONE;
          end else begin
            w_nextState   = WAIT;
            w_nextDivider = c_divReload;
          end
        end
      end
      DONE: begin
        w_nextDone  = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase

    // A register write overrides whatever the run would have done this edge,
    // including a frame acceptance or completion landing on the same edge.
    if (r_writeD) begin
      if (w_mm && w_legal) begin
        w_nextState   = WAIT;
        w_nextPattern = w_mdf;
        w_nextMop     = w_mop[1:0];
        w_nextDivider = c_divReload;
        w_nextFcnt    = 8'd0;
        w_nextDone    = 1'b0;
        w_nextIll     = 1'b0;
      end else begin
        if (w_busy) begin
          w_nextState   = IDLE;
          w_nextFcnt    = r_fcnt;
          w_nextPattern = r_pattern;
          w_nextDone    = r_done;
        end
        if (w_mm && w_illegal) w_nextIll = 1'b1;
      end
    end
  end

`ifdef MTMAINT_PARITY_EN
  // Parity is only presented with a frame so the idle/reset image stays zero.
  assign w_parity = mtMVALID & ~(^r_pattern);
`else
  assign w_parity = 1'b0;
`endif

  assign mtMVALID = (r_state == EMIT);
  assign mtMBUSY  = w_busy;
  assign mtMDONE  = r_done;
  assign mtMILL   = r_ill;
  assign mtBPICLK = (r_state == WAIT) && (r_divider == 16'd0);
  assign mtMFCNT  = r_fcnt;
  assign mtMDAT   = {w_parity, r_pattern};

endmodule
`default_nettype wire

// File: tb/tb_mt_maint_wrap.sv
`default_nettype none
// ============================================================================
// Module   : tb_mt_maint_wrap
// Purpose  : Self-checking bench for mt_maint_wrap (FRAMES=4, BPIDIV=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_mt_maint_wrap;

  localparam int FRAMES = 4;
  localparam int BPIDIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mtMR;
  logic        mtmrWRITE;
  logic [9:0]  mtMDAT;
  logic        mtMVALID;
  logic        mtMREADY;
  logic        mtMBUSY;
  logic        mtMDONE;
  logic        mtMILL;
  logic        mtBPICLK;
  logic [7:0]  mtMFCNT;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] frData[$];
  int         frCyc[$];
  int         bpiN, bpiStall, holdBad, cntBad, lastWriteCyc;
  bit         sawDone;

  mt_maint_wrap #(.FRAMES(FRAMES), .BPIDIV(BPIDIV)) dut (
    .clk(clk), .rst(rst), .mtMR(mtMR), .mtmrWRITE(mtmrWRITE),
    .mtMDAT(mtMDAT), .mtMVALID(mtMVALID), .mtMREADY(mtMREADY),
    .mtMBUSY(mtMBUSY), .mtMDONE(mtMDONE), .mtMILL(mtMILL),
    .mtBPICLK(mtBPICLK), .mtMFCNT(mtMFCNT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mkMR(input logic [8:0] mdf, input logic [3:0] mop,
                                       input logic mm, input logic [1:0] junk);
    return {mdf, junk, mop, mm};
  endfunction

  // Frame k of a run is computed directly from seed and mode.
  function automatic logic [9:0] expFrame(input int seed, input int mop, input int k);
    int v;
    int r;
    logic [8:0] p;
    v = seed;
    if (mop == 2) v = (seed + k) % 512;
    if (mop == 3) begin
      r = k % 9;
      v = ((seed << r) | (seed >> (9 - r))) & 511;
    end
    p = v[8:0];
`ifdef MTMAINT_PARITY_EN
    return {~(^p), p};
`else
    return {1'b0, p};
`endif
  endfunction

  task automatic doWrite(input logic [15:0] v);
    @(negedge clk);
    mtMR = v;
    mtmrWRITE = 1'b1;
    lastWriteCyc = cyc;
    @(negedge clk);
    mtmrWRITE = 1'b0;
  endtask

  task automatic collect(input int budget, input int stallLen, input bit randReady);
    logic       pv, pr, rdy;
    logic [9:0] pd;
    int         stalled;
    pv = 1'b0; pr = 1'b0; pd = '0; stalled = 0;
    frData.delete(); frCyc.delete();
    bpiN = 0; bpiStall = 0; holdBad = 0; cntBad = 0; sawDone = 1'b0;
    for (int i = 0; i < budget && !sawDone; i++) begin
      @(negedge clk);
      if (mtMDONE) begin
        sawDone = 1'b1;
      end else begin
        if (mtBPICLK) begin
          bpiN++;
          if (mtMVALID || (pv && !pr)) bpiStall++;
        end
        if (pv && !pr && (!mtMVALID || mtMDAT !== pd)) holdBad++;
        if (mtMFCNT !== 8'(frData.size())) cntBad++;
        if (mtMVALID && stalled < stallLen) begin
          rdy = 1'b0;
          stalled++;
        end else begin
          rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        mtMREADY = rdy;
        if (mtMVALID && rdy) begin
          frData.push_back(mtMDAT);
          frCyc.push_back(cyc);
        end
        pv = mtMVALID; pr = rdy; pd = mtMDAT;
      end
    end
    mtMREADY = 1'b1;
  endtask

  task automatic waitFrames(input int n, output int got);
    got = 0;
    mtMREADY = 1'b1;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clk);
      if (mtMVALID) got++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mtMR = '0; mtmrWRITE = 1'b0; mtMREADY = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mtMDAT !== 10'h0)  begin failures++; $display("FAIL reset_mdat got=%h exp=000", mtMDAT); end
    checks++; if (mtMVALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mtMVALID); end
    checks++; if (mtMBUSY !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", mtMBUSY); end
    checks++; if (mtMDONE !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", mtMDONE); end
    checks++; if (mtMILL !== 1'b0)   begin failures++; $display("FAIL reset_ill got=%b exp=0", mtMILL); end
    checks++; if (mtBPICLK !== 1'b0) begin failures++; $display("FAIL reset_bpiclk got=%b exp=0", mtBPICLK); end
    checks++; if (mtMFCNT !== 8'd0)  begin failures++; $display("FAIL reset_fcnt got=%0d exp=0", mtMFCNT); end
    rst = 1'b0;
    mtMREADY = 1'b1;
  endtask

  task automatic checkRun(input string nm, input int seed, input int mop);
    checks++; if (!sawDone) begin failures++; $display("FAIL %s_done timeout got=0 exp=1", nm); end
    checks++; if (frData.size() != FRAMES) begin failures++; $display("FAIL %s_nframes got=%0d exp=%0d", nm, frData.size(), FRAMES); end
    for (int k = 0; k < frData.size() && k < FRAMES; k++) begin
      checks++;
      if (frData[k] !== expFrame(seed, mop, k)) begin
        failures++; $display("FAIL %s_frame%0d got=%h exp=%h", nm, k, frData[k], expFrame(seed, mop, k));
      end
    end
    checks++; if (mtMFCNT !== 8'(FRAMES)) begin failures++; $display("FAIL %s_fcnt got=%0d exp=%0d", nm, mtMFCNT, FRAMES); end
    checks++; if (mtMBUSY !== 1'b0) begin failures++; $display("FAIL %s_busy_after got=%b exp=0", nm, mtMBUSY); end
    checks++; if (bpiN != FRAMES) begin failures++; $display("FAIL %s_bpiclk_pulses got=%0d exp=%0d", nm, bpiN, FRAMES); end
    checks++; if (holdBad + bpiStall + cntBad != 0) begin
      failures++; $display("FAIL %s_handshake hold=%0d bpi=%0d cnt=%0d exp=0", nm, holdBad, bpiStall, cntBad);
    end
  endtask

  task automatic test_const;
    int t;
    doWrite(mkMR(9'h0A5, 4'd1, 1'b1, 2'b11));
    t = lastWriteCyc;
    collect(200, 0, 1'b0);
    checkRun("const", 'h0A5, 1);
    checks++; if (frCyc.size() < 1 || frCyc[0] != t + 2 + BPIDIV) begin
      failures++; $display("FAIL const_first_valid got=%0d exp=%0d", frCyc.size() ? frCyc[0] - t : -1, 2 + BPIDIV);
    end
    for (int k = 1; k < frCyc.size(); k++) begin
      checks++;
      if (frCyc[k] - frCyc[k-1] != BPIDIV + 1) begin
        failures++; $display("FAIL const_spacing%0d got=%0d exp=%0d", k, frCyc[k] - frCyc[k-1], BPIDIV + 1);
      end
    end
    checks++; if (mtMDONE !== 1'b1) begin failures++; $display("FAIL const_done_flag got=%b exp=1", mtMDONE); end
  endtask

  task automatic test_patterns;
    doWrite(mkMR(9'h1FE, 4'd2, 1'b1, 2'b00));
    collect(200, 0, 1'b0);
    checkRun("inc", 'h1FE, 2);
    doWrite(mkMR(9'h101, 4'd3, 1'b1, 2'b10));
    collect(200, 0, 1'b0);
    checkRun("rot", 'h101, 3);
  endtask

  task automatic test_backpressure;
    int t, seed, mop;
    seed = int'($urandom_range(0, 511));
    mop  = int'($urandom_range(1, 3));
    doWrite(mkMR(9'(seed), 4'(mop), 1'b1, 2'b01));
    t = lastWriteCyc;
    collect(300, 20, 1'b0);
    checkRun("bp", seed, mop);
    checks++; if (frCyc.size() < 1 || frCyc[0] != t + 2 + BPIDIV + 20) begin
      failures++; $display("FAIL bp_first_accept got=%0d exp=%0d", frCyc.size() ? frCyc[0] - t : -1, 2 + BPIDIV + 20);
    end
  endtask

  task automatic test_abort;
    int got, vcnt, w;
    doWrite(mkMR(9'h055, 4'd1, 1'b1, 2'b00));
    waitFrames(2, got);
    checks++; if (got != 2) begin failures++; $display("FAIL abort_wait2 got=%0d exp=2", got); end
    doWrite(mkMR(9'h055, 4'd1, 1'b0, 2'b00));
    checks++; if (mtMBUSY !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", mtMBUSY); end
    @(negedge clk);
    checks++; if (mtMVALID !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", mtMVALID); end
    checks++; if (mtMBUSY !== 1'b0)  begin failures++; $display("FAIL abort_busy got=%b exp=0", mtMBUSY); end
    checks++; if (mtMDONE !== 1'b0)  begin failures++; $display("FAIL abort_done got=%b exp=0", mtMDONE); end
    checks++; if (mtMFCNT !== 8'd2)  begin failures++; $display("FAIL abort_fcnt got=%0d exp=2", mtMFCNT); end
    vcnt = 0;
    repeat (15) begin @(negedge clk); if (mtMVALID || mtMBUSY) vcnt++; end
    checks++; if (vcnt != 0) begin failures++; $display("FAIL abort_stays_idle got=%0d exp=0", vcnt); end

    doWrite(mkMR(9'h055, 4'd9, 1'b1, 2'b00));
    @(negedge clk);
    checks++; if (mtMILL !== 1'b1)  begin failures++; $display("FAIL ill_set got=%b exp=1", mtMILL); end
    checks++; if (mtMBUSY !== 1'b0) begin failures++; $display("FAIL ill_no_run got=%b exp=0", mtMBUSY); end
    checks++; if (mtMFCNT !== 8'd2) begin failures++; $display("FAIL ill_fcnt got=%0d exp=2", mtMFCNT); end

    // Legal start clears ILL; a later MM=0 write with an illegal MOP must not set it.
    doWrite(mkMR(9'h00F, 4'd2, 1'b1, 2'b00));
    @(negedge clk);
    checks++; if (mtMILL !== 1'b0 || mtMBUSY !== 1'b1) begin
      failures++; $display("FAIL start_clears_ill ill=%b busy=%b exp ill=0 busy=1", mtMILL, mtMBUSY);
    end
    doWrite(mkMR(9'h00F, 4'd12, 1'b0, 2'b00));
    @(negedge clk);
    checks++; if (mtMILL !== 1'b0 || mtMBUSY !== 1'b0) begin
      failures++; $display("FAIL mm0_no_ill ill=%b busy=%b exp ill=0 busy=0", mtMILL, mtMBUSY);
    end

    // Abort landing on the same edge as an acceptance: the frame is not counted.
    doWrite(mkMR(9'h0AA, 4'd1, 1'b1, 2'b00));
    mtMREADY = 1'b0;
    w = 0;
    while (!mtMVALID && w < 50) begin @(negedge clk); w++; end
    checks++; if (!mtMVALID) begin failures++; $display("FAIL lost_valid_timeout got=0 exp=1"); end
    mtMR = mkMR(9'h0AA, 4'd0, 1'b0, 2'b00);
    mtmrWRITE = 1'b1;
    @(negedge clk);
    mtmrWRITE = 1'b0;
    mtMREADY = 1'b1;
    @(negedge clk);
    mtMREADY = 1'b1;
    checks++; if (mtMFCNT !== 8'd0 || mtMVALID !== 1'b0 || mtMBUSY !== 1'b0) begin
      failures++; $display("FAIL abort_vs_accept fcnt=%0d valid=%b busy=%b exp 0/0/0", mtMFCNT, mtMVALID, mtMBUSY);
    end
  endtask

  task automatic test_restart;
    int got;
    doWrite(mkMR(9'h033, 4'd1, 1'b1, 2'b00));
    waitFrames(1, got);
    doWrite(mkMR(9'h1FC, 4'd2, 1'b1, 2'b00));
    collect(200, 0, 1'b0);
    checkRun("restart", 'h1FC, 2);
  endtask

  task automatic test_reset_mid;
    int w;
    doWrite(mkMR(9'h0C3, 4'd3, 1'b1, 2'b00));
    mtMREADY = 1'b0;
    w = 0;
    while (!mtMVALID && w < 50) begin @(negedge clk); w++; end
    checks++; if (!mtMVALID) begin failures++; $display("FAIL rstmid_valid_timeout got=0 exp=1"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({mtMDAT, mtMVALID, mtMBUSY, mtMDONE, mtMILL, mtBPICLK, mtMFCNT} !== '0) begin
      failures++; $display("FAIL rstmid_outputs dat=%h v=%b b=%b d=%b i=%b p=%b c=%0d exp all 0",
                           mtMDAT, mtMVALID, mtMBUSY, mtMDONE, mtMILL, mtBPICLK, mtMFCNT);
    end
    rst = 1'b0;
    mtMREADY = 1'b1;
    doWrite(mkMR(9'h0C3, 4'd3, 1'b1, 2'b00));
    collect(200, 0, 1'b0);
    checkRun("rstmid", 'h0C3, 3);
  endtask

  task automatic test_parity;
    int w;
    logic [9:0] exp0;
`ifdef MTMAINT_PARITY_EN
    exp0 = 10'h200;
`else
    exp0 = 10'h000;
`endif
    doWrite(mkMR(9'h000, 4'd1, 1'b1, 2'b00));
    mtMREADY = 1'b0;
    w = 0;
    while (!mtMVALID && w < 50) begin @(negedge clk); w++; end
    checks++; if (!mtMVALID || mtMDAT !== exp0) begin
      failures++; $display("FAIL parity_zero valid=%b got=%h exp=%h", mtMVALID, mtMDAT, exp0);
    end
    mtMREADY = 1'b1;
    collect(200, 0, 1'b0);
  endtask

  task automatic test_random;
    int seed, mop;
    for (int r = 0; r < 6; r++) begin
      seed = int'($urandom_range(0, 511));
      mop  = int'($urandom_range(1, 3));
      doWrite(mkMR(9'(seed), 4'(mop), 1'b1, 2'($urandom_range(0, 3))));
      collect(500, 0, 1'b1);
      checkRun($sformatf("rand%0d", r), seed, mop);
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_patterns();
    test_backpressure();
    test_abort();
    test_restart();
    test_reset_mid();
    test_parity();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
